// File: rtl/esd_trip_sequencer.sv
// esd_trip_sequencer
//   Central trip arbiter and restart sequencer for the emergency-shutdown
//   controller. Any trip request drops all actuator enables on the next edge,
//   latches the first-out cause and holds the plant in SAFE. After the hold
//   time has elapsed and a clean ACK arrives, enables come back one stage at
//   a time, STAGE_DLY cycles apart.
//
//   Ports:
//     clk          system clock
//     rst_n        synchronous active-low reset
//     trip_req     level trip requests (0 estop_a, 1 estop_b, 2 watchdog, 3 external)
//     ack_pulse    one-cycle ACK strobe
//     out_en       staged actuator enables
//     shutdown     1 whenever the state is not RUN
//     trip_latched sticky record of sources tripped since the last accepted ACK
//     first_out    index of the first tripping source
//     first_valid  first_out holds a valid index
//     state_o      0 SAFE, 1 STARTUP, 2 RUN
//     trip_count   saturating trip-event counter
//
//   Optional feature macro: ESD_TRIP_COUNT_EN enables trip_count; when it is
//   undefined trip_count is tied to zero.

module esd_trip_sequencer #(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned N_OUT       = 4,
   parameter int unsigned STAGE_DLY   = 1000,
   parameter int unsigned HOLD_CYCLES = 500
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [N_SRC-1:0]                              trip_req,
   input  logic                                          ack_pulse,
   output logic [N_OUT-1:0]                              out_en,
   output logic                                          shutdown,
   output logic [N_SRC-1:0]                              trip_latched,
   output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0]  first_out,
   output logic                                          first_valid,
   output logic [1:0]                                    state_o,
   output logic [7:0]                                    trip_count
);

   localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam int unsigned STG_W  = (STAGE_DLY > 1) ? $clog2(STAGE_DLY) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
   localparam logic [STG_W-1:0]  STG_LAST = STG_W'(STAGE_DLY - 1);

   typedef enum logic [1:0] {
      ST_SAFE    = 2'd0,
      ST_STARTUP = 2'd1,
      ST_RUN     = 2'd2,
      ST_BAD     = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [HOLD_W-1:0]   hold_cnt, hold_n;
   logic [STG_W-1:0]    stage_cnt, stage_n;
   logic [N_OUT-1:0]    en_n;
   logic                sd_n;
   logic [N_SRC-1:0]    lat_n;
   logic [SRC_W-1:0]    fo_n;
   logic                fv_n;
   logic [SRC_W-1:0]    low_idx;
   logic                trip_any;

   assign trip_any = |trip_req;
   assign state_o  = 2'(state);

   // Lowest set trip index; descending scan so the lowest index wins
   always_comb begin
      low_idx = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (trip_req[i]) low_idx = SRC_W'(i);
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_SAFE;
         out_en       <= '0;
         shutdown     <= 1'b1;
         trip_latched <= '0;
         first_out    <= '0;
         first_valid  <= 1'b0;
         hold_cnt     <= '0;
         stage_cnt    <= '0;
      end else begin
         state        <= state_n;
         out_en       <= en_n;
         shutdown     <= sd_n;
         trip_latched <= lat_n;
         first_out    <= fo_n;
         first_valid  <= fv_n;
         hold_cnt     <= hold_n;
         stage_cnt    <= stage_n;
      end
   end

   // Next-state and next-output logic; a trip overrides everything else
   always_comb begin
      state_n = state;
      en_n    = out_en;
      sd_n    = shutdown;
      lat_n   = trip_latched | trip_req;
      fo_n    = first_out;
      fv_n    = first_valid;
      hold_n  = hold_cnt;
      stage_n = stage_cnt;

      if (!first_valid && trip_any) begin
         fo_n = low_idx;
         fv_n = 1'b1;
      end

      if (trip_any) begin
         state_n = ST_SAFE;
         en_n    = '0;
         sd_n    = 1'b1;
         hold_n  = '0;
         stage_n = '0;
      end else begin
         case (state)
            ST_SAFE: begin
               en_n    = '0;
               sd_n    = 1'b1;
               stage_n = '0;
               if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + HOLD_W'(1);
               if (ack_pulse && (hold_cnt == HOLD_MAX)) begin
                  lat_n  = '0;
                  fv_n   = 1'b0;
                  hold_n = '0;
                  en_n   = N_OUT'(1);
                  if (N_OUT == 1) begin
                     state_n = ST_RUN;
                     sd_n    = 1'b0;
                  end else begin
                     state_n = ST_STARTUP;
                  end
               end
            end
            ST_STARTUP: begin
               // Each stage advance adds the next enable above the highest one set
               if (stage_cnt == STG_LAST) begin
                  stage_n = '0;
                  en_n    = out_en | (out_en << 1);
                  if (en_n[N_OUT-1]) begin
                     state_n = ST_RUN;
                     sd_n    = 1'b0;
                  end
               end else begin
                  stage_n = stage_cnt + STG_W'(1);
               end
            end
            ST_RUN: begin
               en_n = '1;
               sd_n = 1'b0;
            end
            default: begin
               state_n = ST_SAFE;
               en_n    = '0;
               sd_n    = 1'b1;
               hold_n  = '0;
               stage_n = '0;
            end
         endcase
      end
   end

`ifdef ESD_TRIP_COUNT_EN
   logic       trip_any_q;
   logic [7:0] cnt_q;

   // Count rising edges of the combined trip request, saturating at 255
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         trip_any_q <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         trip_any_q <= trip_any;
         if (trip_any && !trip_any_q && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
      end
   end

   assign trip_count = cnt_q;
`else
   assign trip_count = 8'd0;
`endif

endmodule

// File: tb/tb_esd_trip_sequencer.sv
// tb_esd_trip_sequencer
//   Directed self-checking bench for esd_trip_sequencer with default
//   parameters: a vector table for single-cycle trip/ACK behaviour plus
//   hand-written sequences for hold timing, staged startup and reset.

module tb_esd_trip_sequencer;

   localparam int STAGE = 1000;
   localparam int HOLD  = 500;

   logic       clk;
   logic       rst_n;
   logic [3:0] trip_req;
   logic       ack_pulse;
   logic [3:0] out_en;
   logic       shutdown;
   logic [3:0] trip_latched;
   logic [1:0] first_out;
   logic       first_valid;
   logic [1:0] state_o;
   logic [7:0] trip_count;

   int n_cmp = 0;
   int n_err = 0;

   esd_trip_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .trip_req     (trip_req),
      .ack_pulse    (ack_pulse),
      .out_en       (out_en),
      .shutdown     (shutdown),
      .trip_latched (trip_latched),
      .first_out    (first_out),
      .first_valid  (first_valid),
      .state_o      (state_o),
      .trip_count   (trip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] trip;
      logic       ack;
      logic [3:0] en;
      logic       sd;
      logic [1:0] st;
      logic [3:0] lat;
      logic [1:0] fo;
      logic       fv;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[5];

   // Expected trip_count depends on whether the counter is built
   function automatic logic [7:0] ecnt(input logic [7:0] c);
`ifdef ESD_TRIP_COUNT_EN
      return c;
`else
      return 8'd0 & c;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] tr, input logic ak);
      trip_req  = tr;
      ack_pulse = ak;
      @(posedge clk);
      #1;
      ack_pulse = 1'b0;
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 1'b0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".en"},  32'(out_en), 32'h0);
      chk({tag, ".sd"},  32'(shutdown), 32'h1);
      chk({tag, ".st"},  32'(state_o), 32'h0);
      chk({tag, ".lat"}, 32'(trip_latched), 32'h0);
      chk({tag, ".fo"},  32'(first_out), 32'h0);
      chk({tag, ".fv"},  32'(first_valid), 32'h0);
      chk({tag, ".cnt"}, 32'(trip_count), 32'h0);
   endtask

   // Staged startup after an accepted ACK: checks the edge before and at each stage
   task automatic startup_seq(input string tag);
      logic [3:0] en_exp;
      en_exp = 4'b0001;
      chk({tag, ".ack_en"}, 32'(out_en), 32'(en_exp));
      chk({tag, ".ack_st"}, 32'(state_o), 32'h1);
      chk({tag, ".ack_sd"}, 32'(shutdown), 32'h1);
      for (int s = 1; s < 4; s++) begin
         run_idle(STAGE - 1);
         chk({tag, ".pre_en"}, 32'(out_en), 32'(en_exp));
         step(4'b0000, 1'b0);
         en_exp = (en_exp << 1) | 4'b0001;
         chk({tag, ".stg_en"}, 32'(out_en), 32'(en_exp));
      end
      chk({tag, ".run_st"}, 32'(state_o), 32'h2);
      chk({tag, ".run_sd"}, 32'(shutdown), 32'h0);
   endtask

   initial begin
      rst_n     = 1'b0;
      trip_req  = 4'b0000;
      ack_pulse = 1'b0;

      // trip, ack -> en, sd, st, lat, fo, fv, cnt
      tbl[0] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0100, 2'd2, 1'b1, 8'd1};
      tbl[1] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0101, 2'd2, 1'b1, 8'd1};
      tbl[2] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0101, 2'd2, 1'b1, 8'd1};
      tbl[3] = '{4'b0010, 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0111, 2'd2, 1'b1, 8'd2};
      tbl[4] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0111, 2'd2, 1'b1, 8'd2};

      // Reset values
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // Early ACK ignored, ACK after the hold time starts the staged sequence
      run_idle(99);
      step(4'b0000, 1'b1);
      chk("early_ack.st", 32'(state_o), 32'h0);
      chk("early_ack.en", 32'(out_en), 32'h0);
      run_idle(499);
      step(4'b0000, 1'b1);
      startup_seq("hold");

      // Trip in RUN, first-out retention, ignored ACKs
      for (int v = 0; v < 5; v++) begin
         step(tbl[v].trip, tbl[v].ack);
         chk($sformatf("vec%0d.en", v),  32'(out_en),       32'(tbl[v].en));
         chk($sformatf("vec%0d.sd", v),  32'(shutdown),     32'(tbl[v].sd));
         chk($sformatf("vec%0d.st", v),  32'(state_o),      32'(tbl[v].st));
         chk($sformatf("vec%0d.lat", v), 32'(trip_latched), 32'(tbl[v].lat));
         chk($sformatf("vec%0d.fo", v),  32'(first_out),    32'(tbl[v].fo));
         chk($sformatf("vec%0d.fv", v),  32'(first_valid),  32'(tbl[v].fv));
         chk($sformatf("vec%0d.cnt", v), 32'(trip_count),   32'(ecnt(tbl[v].cnt)));
      end

      // ACK while a source is held has no effect
      for (int i = 0; i < 600; i++) step(4'b0010, (i % 50) == 0);
      chk("held.st", 32'(state_o), 32'h0);
      chk("held.lat", 32'(trip_latched), 32'h7);
      chk("held.cnt", 32'(trip_count), 32'(ecnt(8'd3)));
      // One cycle short of the hold time, then exactly at it
      run_idle(HOLD - 1);
      step(4'b0000, 1'b1);
      chk("hold_m1.st", 32'(state_o), 32'h0);
      chk("hold_m1.lat", 32'(trip_latched), 32'h7);
      step(4'b0000, 1'b1);
      chk("hold_ok.lat", 32'(trip_latched), 32'h0);
      chk("hold_ok.fv", 32'(first_valid), 32'h0);
      chk("hold_ok.en", 32'(out_en), 32'h1);
      chk("hold_ok.st", 32'(state_o), 32'h1);

      // Trip during stage 2 of startup
      run_idle(1499);
      chk("stg2.en", 32'(out_en), 32'h3);
      step(4'b0001, 1'b0);
      chk("stg2_trip.en", 32'(out_en), 32'h0);
      chk("stg2_trip.st", 32'(state_o), 32'h0);
      chk("stg2_trip.sd", 32'(shutdown), 32'h1);
      chk("stg2_trip.fo", 32'(first_out), 32'h0);
      chk("stg2_trip.fv", 32'(first_valid), 32'h1);
      chk("stg2_trip.lat", 32'(trip_latched), 32'h1);
      chk("stg2_trip.cnt", 32'(trip_count), 32'(ecnt(8'd4)));
      run_idle(10);
      step(4'b0000, 1'b1);
      chk("restart_early.st", 32'(state_o), 32'h0);
      run_idle(HOLD - 11);
      step(4'b0000, 1'b1);
      chk("restart.st", 32'(state_o), 32'h1);
      chk("restart.en", 32'(out_en), 32'h1);

      // Reset in the middle of startup
      run_idle(2499);
      chk("mid.en", 32'(out_en), 32'h7);
      rst_n = 1'b0;
      step(4'b0000, 1'b0);
      chk_reset_vals("mid_reset");
      rst_n = 1'b1;
      run_idle(10);
      step(4'b0000, 1'b1);
      chk("post_reset_ack.st", 32'(state_o), 32'h0);

      // Simultaneous trips resolve to the lowest index
      step(4'b1010, 1'b0);
      chk("simul.fo", 32'(first_out), 32'h1);
      chk("simul.lat", 32'(trip_latched), 32'hA);
      chk("simul.cnt", 32'(trip_count), 32'(ecnt(8'd1)));
      step(4'b0000, 1'b0);

      // Counter saturation
      for (int i = 0; i < 300; i++) begin
         step(4'b0001, 1'b0);
         step(4'b0000, 1'b0);
      end
      chk("sat.cnt", 32'(trip_count), 32'(ecnt(8'd255)));
      chk("sat.lat", 32'(trip_latched), 32'hB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
